// File: rtl/elastic_skid_buffer.sv
// elastic_skid_buffer: DEPTH-entry elastic buffer for valid/ready channels.
// Every output comes straight from a flop, which breaks both the forward
// (data/valid) and the backward (ready) timing paths. The head beat always
// sits in the output register; the remaining DEPTH-1 beats live in a ring.
module elastic_skid_buffer #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_WIDTH-1:0]        s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int RING = DEPTH - 1;
  localparam int PW   = (RING > 1) ? $clog2(RING) : 1;

  localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [PW-1:0] PTR_LAST = PW'(RING - 1);

  logic [DATA_WIDTH-1:0] ring_mem [RING];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  logic          push;
  logic          pop;
  logic [CW-1:0] count_next;
  logic          load_direct;
  logic          load_ring;
  logic          ring_wr;

  // Ring pointers wrap modulo DEPTH-1, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Handshakes, next occupancy and where the incoming/outgoing beat goes.
  always_comb begin
    push       = s_valid & s_ready;
    pop        = m_valid & m_ready;
    count_next = count;
    if (push && !pop)
      count_next = count + ONE_C;
    else if (pop && !push)
      count_next = count - ONE_C;
    // The output register takes s_data directly when it is (or is about to
    // be) the only beat held; otherwise it refills from the ring head.
    load_direct = push && ((count == '0) || (pop && (count == ONE_C)));
    load_ring   = pop && (count > ONE_C);
    ring_wr     = push && !load_direct;
  end

  // Control state and output register; flush discards any same-cycle handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count       <= '0;
      s_ready     <= 1'b0;
      m_valid     <= 1'b0;
      almost_full <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      m_data      <= '0;
    end else if (flush) begin
      count       <= '0;
      s_ready     <= 1'b1;
      m_valid     <= 1'b0;
      almost_full <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      count       <= count_next;
      s_ready     <= (count_next < FULL_C);
      m_valid     <= (count_next != '0);
      almost_full <= (count_next >= AFULL_C);
      if (ring_wr)
        wr_ptr <= ptr_inc(wr_ptr);
      if (load_ring)
        rd_ptr <= ptr_inc(rd_ptr);
      // m_data only moves on a pop or a load into an empty buffer, so a
      // stalled beat is never disturbed by a push landing in the ring.
      if (load_direct)
        m_data <= s_data;
      else if (load_ring)
        m_data <= ring_mem[rd_ptr];
    end
  end

  // Ring payload storage; contents are qualified by the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (ring_wr && !flush)
      ring_mem[wr_ptr] <= s_data;
  end

endmodule

// File: tb/tb_elastic_skid_buffer.sv
// Testbench for elastic_skid_buffer: directed scenarios followed by a
// randomized run, all compared against a queue-based reference model.
module tb_elastic_skid_buffer;

  localparam int DATA_WIDTH   = 8;
  localparam int DEPTH        = 4;
  localparam int AFULL_THRESH = DEPTH - 1;
  localparam int CW           = $clog2(DEPTH + 1);

  logic                  clk = 1'b0;
  logic                  resetn;
  logic                  flush;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [CW-1:0]         count;
  logic                  almost_full;

  elastic_skid_buffer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH       (DEPTH),
    .AFULL_THRESH(AFULL_THRESH)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .count      (count),
    .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  // Reference model: contents in order, plus expected upstream ready.
  logic [DATA_WIDTH-1:0] q[$];
  bit                    sready_m;
  bit                    stall_prev;
  logic [DATA_WIDTH-1:0] prev_data;
  bit                    last_acc;
  int                    total = 0;
  int                    bad   = 0;
  int                    idx;
  int                    seen_af;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs against the model at the falling edge,
  // drive inputs, then advance the model at the rising edge.
  task automatic step(input bit sv, input logic [DATA_WIDTH-1:0] sd, input bit mr, input bit fl);
    bit pu;
    bit po;
    @(negedge clk);
    chk("count",       32'(count),       32'(q.size()));
    chk("m_valid",     32'(m_valid),     32'(q.size() != 0));
    chk("s_ready",     32'(s_ready),     32'(sready_m));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= AFULL_THRESH));
    if (q.size() != 0) chk("m_data", 32'(m_data), 32'(q[0]));
    if (stall_prev)    chk("stable", 32'(m_data), 32'(prev_data));
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    flush   = fl;
    pu = sv && sready_m;
    po = (q.size() != 0) && mr;
    stall_prev = (q.size() != 0) && !mr && !fl;
    if (stall_prev) prev_data = q[0];
    last_acc = pu && !fl;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (po) void'(q.pop_front());
      if (pu) q.push_back(sd);
    end
    sready_m = (q.size() < DEPTH);
  endtask

  task automatic chk_all_clear(input string tag);
    chk({tag, "_count"},   32'(count),       32'(0));
    chk({tag, "_m_valid"}, 32'(m_valid),     32'(0));
    chk({tag, "_m_data"},  32'(m_data),      32'(0));
    chk({tag, "_afull"},   32'(almost_full), 32'(0));
    chk({tag, "_s_ready"}, 32'(s_ready),     32'(0));
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    sready_m = 1'b0; stall_prev = 1'b0; prev_data = '0; last_acc = 1'b0;
    #1;
    chk_all_clear("reset");
    repeat (2) @(posedge clk);
    #4 resetn = 1'b1;

    // Streaming: three beats with the sink always ready.
    step(0, 8'h00, 1, 0);
    step(1, 8'h11, 1, 0);
    #1 chk("first_beat", 32'(m_data), 32'h11);
    step(1, 8'h22, 1, 0);
    step(1, 8'h33, 1, 0);
    repeat (3) step(0, 8'h00, 1, 0);

    // Fill while the sink is stalled; the source holds each beat until taken.
    idx = 0;
    seen_af = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 8'(8'hA0 + idx), 0, 0);
      if (last_acc) idx++;
      #1;
      if (count == CW'(3)) begin
        chk("afull_at_3", 32'(almost_full), 32'(1));
        seen_af++;
      end
    end
    chk("afull_seen", 32'(seen_af), 32'(1));
    chk("accepted",    32'(idx),         32'(4));
    chk("full_count",  32'(count),       32'(4));
    chk("full_sready", 32'(s_ready),     32'(0));
    chk("hold_a0",     32'(m_data),      32'hA0);
    chk("full_afull",  32'(almost_full), 32'(1));

    // Drain from full with the source still pushing 0xA4, 0xA5.
    for (int i = 0; i < 10; i++) begin
      step(idx < 6, 8'(8'hA0 + idx), 1, 0);
      if (last_acc) idx++;
    end
    chk("drain_accepted", 32'(idx), 32'(6));

    // Flush at count=3 together with a push and a pop.
    for (int i = 0; i < 3; i++) step(1, 8'(8'hC0 + i), 0, 0);
    #1 chk("pre_flush_count", 32'(count), 32'(3));
    step(1, 8'hEE, 1, 1);
    #1;
    chk("flush_count",   32'(count),       32'(0));
    chk("flush_m_valid", 32'(m_valid),     32'(0));
    chk("flush_s_ready", 32'(s_ready),     32'(1));
    chk("flush_afull",   32'(almost_full), 32'(0));
    repeat (3) step(0, 8'h00, 1, 0);

    // Asynchronous reset pulse mid-cycle at count=2.
    step(1, 8'h5A, 0, 0);
    step(1, 8'h5B, 0, 0);
    #1 chk("pre_reset_count", 32'(count), 32'(2));
    #1 resetn = 1'b0;
    #1 chk_all_clear("async_reset");
    q.delete(); sready_m = 1'b0; stall_prev = 1'b0;
    #1 resetn = 1'b1;
    step(1, 8'h66, 1, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    step(1, 8'h77, 0, 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 1, 0);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 10000; i++)
      step(bit'($urandom % 2), 8'($urandom), bit'($urandom % 2), ($urandom % 97) == 0);
    step(0, 8'h00, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/elastic_skid_buffer.md
Name: elastic_skid_buffer

Overview:
- Parametrised successor to the 2-entry AXI-stream skid buffer: a DEPTH-entry elastic buffer for valid/ready channels in the fullchip AXI fabric.
- All outputs are driven from flops, so it breaks both the forward (data/valid) and backward (ready) timing paths.
- Adds occupancy reporting, an almost-full flag and a synchronous flush, for use on long AXI channel hops and in bursty master/slave bridges.

Parameters:
DATA_WIDTH, 8, payload width in bits (>=1)
DEPTH, 4, total storage in entries including output register; power of 2, >=2
AFULL_THRESH, DEPTH-1, almost_full asserts when count >= AFULL_THRESH; range 1..DEPTH

Ports:
clk  input  1  clock, rising edge
resetn  input  1  reset, asynchronous assert, active-low
flush  input  1  synchronous discard of all buffered entries
s_valid  input  1  upstream valid
s_ready  output  1  upstream ready (registered)
s_data  input  DATA_WIDTH  upstream payload
m_valid  output  1  downstream valid (registered)
m_ready  input  1  downstream ready
m_data  output  DATA_WIDTH  downstream payload (registered)
count  output  $clog2(DEPTH+1)  entries held, 0..DEPTH
almost_full  output  1  count >= AFULL_THRESH (registered)

Behaviour:
- Reset is asynchronous and active-low: clk and resetn; resetn low asynchronously clears state. Outputs while resetn is low: count=0, m_valid=0, m_data=0, almost_full=0, s_ready=0. s_ready rises at the first clk edge after resetn deasserts.
- Handshakes:
  - push = s_valid & s_ready.
  - pop = m_valid & m_ready.
  - Both are evaluated at the same edge.
- Storage and ordering:
  - Strict FIFO order; no drops or duplicates except on flush.
  - Storage is the output register plus a (DEPTH-1)-entry ring. Ring pointers wrap modulo DEPTH-1 (or an equivalent scheme with identical ports behaviour).
- Latency: a push into an empty buffer produces m_valid=1 with that data one cycle later, i.e. visible after the accepting edge. There is no combinational path from s_* to m_* or from m_ready to s_ready.
- Ready and valid:
  - s_ready = (count < DEPTH), from flops.
  - m_valid = (count != 0).
  - count_next = count + push - pop.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and throughput is 1 beat/cycle.
- Full (count=DEPTH): s_ready=0. A pop frees one slot and s_ready=1 on the next cycle. The one-cycle bubble at full is accepted behaviour.
- Empty (count=0): m_valid=0 and m_data holds its last value. A push with count=0 loads the output register directly.
- Stability: while m_valid=1 and m_ready=0, m_data and m_valid must hold constant (AXI rule).
- Data must never change under a stalled beat, including when a push lands in the ring during the stall.
- almost_full is registered and tracks count_next against AFULL_THRESH, so it is coincident with count.
- Flush:
  - flush=1 at an edge sets count=0, m_valid=0, pointers to 0, and almost_full=0.
  - s_ready=1 the next cycle.
  - A push or pop handshake in the same cycle is discarded (flush wins).
  - m_data value after flush is don't-care.
- Reset mid-transfer: all contents are lost immediately. No beat is presented after resetn deasserts until a new push occurs.
- Invariant: count never exceeds DEPTH or underflows, under any combination of s_valid, m_ready and flush.

Test Plan:
- Reset, then push 0x11,0x22,0x33 with m_ready=1 continuous -> m_data 0x11,0x22,0x33 on consecutive cycles, first beat one cycle after its push; count toggles 0→1 and stays 1 while streaming.
- DEPTH=4, m_ready=0, s_valid=1 with data 0xA0..0xA5 -> exactly 0xA0..0xA3 accepted; s_ready=0 from count=4; almost_full=1 at count=3; m_data stays 0xA0 throughout.
- From full, raise m_ready=1 with s_valid=1 held -> output 0xA0,0xA1,0xA2,0xA3 then 0xA4,0xA5 in order; single s_ready bubble only at the full point.
- Random s_valid/m_ready (50%) for 10k cycles against a scoreboard queue -> zero ordering mismatches; m_data stable whenever m_valid & !m_ready; count equals queue length every cycle.
- count=3 with push and pop in the same cycle as flush=1 -> next cycle count=0, m_valid=0, s_ready=1, almost_full=0; the pushed beat never appears.
- resetn pulsed low asynchronously mid-cycle at count=2 -> outputs clear immediately without a clock; after release s_ready=1 at the first edge, m_valid=0 until a new push.
